// File: rtl/raifes_jtag_host.sv
// JTAG host: runs TAP reset, IR/DR scans and idle clocks on a TCK divided from clk.
// tms/tdi launch as tck is driven low; tdo is captured as tck is driven high.
module raifes_jtag_host #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_len,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    typedef enum logic [2:0] {IDLE, RESET, SEL, SHIFT, EXIT, IDLECLK, DONE} state_t;

    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, next_state;
    logic [7:0]  div_cnt;
    logic [6:0]  pulse_cnt, next_idx, target;
    logic [1:0]  op_q, op_sel;
    logic [6:0]  len_q;
    logic [63:0] data_q, capture;
    logic        err_q, quiet;
    logic        running, tick, rise, fall, pulse_last, len_ok;
    logic        accept, start_pulse, tms_d, tdi_d;

    assign running    = state inside {RESET, SEL, SHIFT, EXIT, IDLECLK};
    assign tick       = running && (div_cnt == DIV_LAST);
    assign rise       = tick && !tck;
    assign fall       = tick && tck;
    assign len_ok     = (cmd_len != 7'd0) && (cmd_len <= 7'd64);
    assign pulse_last = (pulse_cnt == target - 7'd1);

    // Number of TCK pulses issued by each sequencing state.
    always_comb begin
        target = 7'd1;
        case (state)
            RESET:         target = 7'd6;
            SEL:           target = (op_q == OP_IR) ? 7'd4 : 7'd3;
            SHIFT, IDLECLK: target = len_q;
            EXIT:          target = 7'd2;
            default:       target = 7'd1;
        endcase
    end

    // NOTE: state holds through reset as RESET so the TAP is resynchronised after any nreset.
    always_ff @(posedge clk) begin
        if (!nreset) state <= RESET;
        else         state <= next_state;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        next_state  = state;
        next_idx    = pulse_cnt;
        start_pulse = 1'b0;
        accept      = 1'b0;
        op_sel      = op_q;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept      = 1'b1;
                    start_pulse = 1'b1;
                    next_idx    = 7'd0;
                    op_sel      = cmd_op;
                    if (cmd_op == OP_RST)       next_state = RESET;
                    else if (!len_ok)           next_state = DONE;
                    else if (cmd_op == OP_IDLE) next_state = IDLECLK;
                    else                        next_state = SEL;
                end
            end
            DONE: next_state = IDLE;
            default: begin
                if (fall) begin
                    start_pulse = 1'b1;
                    if (pulse_last) begin
                        next_idx = 7'd0;
                        case (state)
                            SEL:     next_state = SHIFT;
                            SHIFT:   next_state = EXIT;
                            default: next_state = DONE;
                        endcase
                    end else begin
                        next_idx = pulse_cnt + 7'd1;
                    end
                end
            end
        endcase

        // Line levels for the pulse that starts with this tck falling edge.
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (next_state)
            RESET: tms_d = (next_idx < 7'd5);
            SEL:   tms_d = (next_idx == 7'd0) || ((op_sel == OP_IR) && (next_idx == 7'd1));
            SHIFT: begin
                tms_d = (next_idx == len_q - 7'd1);
                tdi_d = data_q[next_idx[5:0]];
            end
            EXIT:  tms_d = (next_idx == 7'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            div_cnt   <= 8'd0;
            pulse_cnt <= 7'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            op_q      <= 2'b00;
            len_q     <= 7'd0;
            err_q     <= 1'b0;
            quiet     <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            cmd_ready <= (state == IDLE) && (next_state == IDLE);
            div_cnt   <= (running && !tick) ? div_cnt + 8'd1 : 8'd0;
            if (tick) tck <= !tck;
            if (start_pulse) begin
                tms       <= tms_d;
                tdi       <= tdi_d;
                pulse_cnt <= next_idx;
            end
            if (accept) begin
                op_q  <= cmd_op;
                len_q <= cmd_len;
                err_q <= (cmd_op != OP_RST) && !len_ok;
            end
            // The autonomous post-reset sequence completes silently.
            if (state == DONE) begin
                quiet <= 1'b0;
                if (!quiet) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= capture;
                    rsp_err   <= err_q;
                end
            end
        end
    end

    // NOTE: data_q and capture carry no reset; both are loaded at acceptance before any use.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q  <= cmd_data;
            capture <= '0;
        end else if (rise && state == SHIFT) begin
            capture[pulse_cnt[5:0]] <= tdo;
        end
    end

endmodule

// File: tb/tb_raifes_jtag_host.sv
// Randomised bench for raifes_jtag_host: expected pulse streams and captures are
// built from the command rules, with tdo supplied from a random vector per command.
module tb_raifes_jtag_host;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [6:0]  cmd_len = 7'd0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_data;
    logic        tck, tms, tdi, tdo;

    int tests = 0, fails = 0;
    int rise_cnt = 0, high_cycles = 0, rv_count = 0, stable_err = 0, sel_n = 3;
    logic [127:0] obs_tms = '0, obs_tdi = '0;
    logic [63:0]  tdo_vec = '0;
    logic         junk_bit = 1'b0;
    logic         prev_tms = 1'b1, prev_tdi = 1'b0;

    raifes_jtag_host #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Target device: shift pulse i presents tdo_vec[i]; other pulses see junk_bit.
    always_comb begin
        int k;
        k = rise_cnt - sel_n;
        tdo = (k >= 0 && k < 64) ? tdo_vec[k[5:0]] : junk_bit;
    end

    always @(posedge tck) begin
        if (rise_cnt < 128) begin
            obs_tms[rise_cnt[6:0]] = tms;
            obs_tdi[rise_cnt[6:0]] = tdi;
        end
        rise_cnt++;
    end

    always @(negedge clk) begin
        if (tck) high_cycles++;
        if (rsp_valid) rv_count++;
        if (tck && (tms !== prev_tms || tdi !== prev_tdi)) stable_err++;
        prev_tms = tms;
        prev_tdi = tdi;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_monitor();
        rise_cnt    = 0;
        high_cycles = 0;
        stable_err  = 0;
        obs_tms     = '0;
        obs_tdi     = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    // After nreset releases: 5 pulses tms=1, one tms=0, no response, then ready.
    task automatic boot_check(input string tag);
        int n = 0;
        int rv0;
        reset_monitor();
        rv0 = rv_count;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_pulses"}, rise_cnt, 6);
        check({tag, "_tms"}, obs_tms, 128'b011111);
        check({tag, "_tck_high_cycles"}, high_cycles, 6 * CLK_DIV);
        check({tag, "_no_rsp"}, rv_count - rv0, 0);
        check({tag, "_rsp_regs"}, {rsp_err, rsp_data}, 65'd0);
        check({tag, "_stable"}, stable_err, 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
        logic [127:0] exp_tms, exp_tdi, mask;
        logic [63:0]  exp_data;
        logic         bad;
        int p, lat, rv0, ready_err;
        string tag;
        tag = $sformatf("op%0d_len%0d", op, len);
        wait_ready(tag);

        bad      = (op != 2'b10) && (len == 7'd0 || len > 7'd64);
        tdo_vec  = {$urandom, $urandom};
        junk_bit = 1'($urandom);
        sel_n    = (op == 2'b01) ? 4 : 3;
        exp_tms  = '0;
        exp_tdi  = '0;
        mask     = '0;
        exp_data = '0;
        p = 0;
        if (op == 2'b10) begin
            for (int i = 0; i < 6; i++) begin
                exp_tms[p] = (i < 5);
                p++;
            end
        end else if (!bad && op == 2'b11) begin
            for (int i = 0; i < int'(len); i++) begin
                mask[p] = 1'b1;
                p++;
            end
        end else if (!bad) begin
            exp_tms[p] = 1'b1;
            p++;
            if (op == 2'b01) begin
                exp_tms[p] = 1'b1;
                p++;
            end
            p += 2;
            for (int i = 0; i < int'(len); i++) begin
                exp_tms[p]  = (i == int'(len) - 1);
                exp_tdi[p]  = data[i];
                mask[p]     = 1'b1;
                exp_data[i] = tdo_vec[i];
                p++;
            end
            exp_tms[p] = 1'b1;
            p += 2;
        end

        reset_monitor();
        rv0 = rv_count;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        lat = 0;
        ready_err = 0;
        // Keep cmd_valid high with changing junk while busy: it must be ignored.
        do begin
            @(negedge clk);
            lat++;
            if (cmd_ready) ready_err++;
            cmd_op   = 2'($urandom);
            cmd_len  = 7'($urandom);
            cmd_data = {$urandom, $urandom};
        end while (!rsp_valid && lat < 2000);
        cmd_valid = 1'b0;

        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_data"}, rsp_data, exp_data);
        check({tag, "_rsp_err"}, rsp_err, bad);
        if (bad) check({tag, "_err_latency"}, lat, 2);
        @(negedge clk);
        #1;
        check({tag, "_pulse_end_ready"}, {rsp_valid, cmd_ready}, 2'b01);
        check({tag, "_rsp_hold"}, {rsp_err, rsp_data}, {bad, exp_data});
        check({tag, "_pulses"}, rise_cnt, p);
        check({tag, "_tms"}, obs_tms, exp_tms);
        check({tag, "_tdi"}, obs_tdi & mask, exp_tdi);
        check({tag, "_tck_high_cycles"}, high_cycles, p * CLK_DIV);
        check({tag, "_stable"}, stable_err, 0);
        check({tag, "_one_rsp"}, rv_count - rv0, 1);
        check({tag, "_busy_not_ready"}, ready_err, 0);
    endtask

    initial begin
        logic [1:0] op;
        logic [6:0] len;
        int n;

        nreset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, rsp_data},
              {6'b010000, 64'd0});
        nreset = 1'b1;
        boot_check("boot");

        run_cmd(2'b01, 7'd5, 64'h01);
        run_cmd(2'b00, 7'd32, 64'h0);
        run_cmd(2'b00, 7'd0, {$urandom, $urandom});
        run_cmd(2'b11, 7'd65, {$urandom, $urandom});
        run_cmd(2'b00, 7'd64, {$urandom, $urandom});
        run_cmd(2'b01, 7'd1, {$urandom, $urandom});
        run_cmd(2'b10, 7'd0, {$urandom, $urandom});
        run_cmd(2'b10, 7'd99, {$urandom, $urandom});
        run_cmd(2'b00, 7'd41, {23'd0, 32'h1, 2'b00, 7'h10} << 0);
        run_cmd(2'b11, 7'd10, {$urandom, $urandom});
        run_cmd(2'b01, 7'd127, {$urandom, $urandom});

        // Abort a 41-bit DR scan while shift bit 20 is on the wire.
        wait_ready("abort");
        reset_monitor();
        sel_n    = 3;
        tdo_vec  = {$urandom, $urandom};
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = 7'd41;
        cmd_data  = {$urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rise_cnt < 24 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit20", rise_cnt, 24);
        nreset = 1'b0;
        @(negedge clk);
        check("abort_reset_outputs", {tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, rsp_data},
              {6'b010000, 64'd0});
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        boot_check("abort_boot");

        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)       len = 7'($urandom_range(65, 127));
            else if ($urandom_range(0, 15) == 0) len = 7'd0;
            else                                 len = 7'($urandom_range(1, 64));
            run_cmd(op, len, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/raifes_jtag_host.md
RAIFES_JTAG_HOST -- requirements
Module: raifes_jtag_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: TCK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all logic SHALL be clocked on its rising edge.
REQ-003 SHALL have port nreset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block idle and able to accept a command.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 DR scan, 01 IR scan, 10 TAP reset, 11 idle clocks.
REQ-007 SHALL have port cmd_len, input, 7 bits: number of shift bits or idle pulses, 1..64.
REQ-008 SHALL have port cmd_data, input, 64 bits: TDI data, bit 0 shifted first.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rsp_data, output, 64 bits: captured TDO, bit 0 captured first.
REQ-011 SHALL have port rsp_err, output, 1 bit: command rejected (illegal cmd_len).
REQ-012 SHALL have ports tck, tms and tdi, output, 1 bit each: JTAG drive lines.
REQ-013 SHALL have port tdo, input, 1 bit: JTAG return line.

Function
REQ-014 A command SHALL be accepted in a cycle where cmd_valid and cmd_ready are both 1; cmd_op, cmd_len and cmd_data SHALL be registered in that cycle.
REQ-015 cmd_ready SHALL be 0 from the acceptance cycle until the cycle after the rsp_valid pulse.
REQ-016 tck SHALL toggle every CLK_DIV clk cycles while a sequence runs and SHALL rest at 0 when idle; one TCK pulse is 2*CLK_DIV clk cycles.
REQ-017 tms and tdi SHALL change only in the cycle in which tck is driven low; tdo SHALL be sampled in the cycle in which tck is driven high.
REQ-018 FSM states SHALL be IDLE, RESET, SEL, SHIFT, EXIT, IDLECLK and DONE.
REQ-019 RESET SHALL issue 5 pulses with tms=1, then 1 pulse with tms=0, leaving the TAP in Run-Test/Idle, then go to DONE.
REQ-020 SEL SHALL issue tms pattern 1,0,0 for a DR scan (3 pulses) or 1,1,0,0 for an IR scan (4 pulses), ending in Shift-DR or Shift-IR.
REQ-021 SHIFT SHALL issue cmd_len pulses with tdi=cmd_data[i] on pulse i, tms=0 on every pulse except tms=1 on the last.
REQ-022 On each SHIFT pulse, tdo sampled at that pulse's rising edge SHALL be stored in rsp_data[i].
REQ-023 rsp_data bits at index cmd_len and above SHALL be 0.
REQ-024 EXIT SHALL issue pulses with tms=1 (Update) then tms=0 (Run-Test/Idle), then go to DONE.
REQ-025 Total pulse counts SHALL be len+5 for a DR scan, len+6 for an IR scan, 6 for a TAP reset, and len for idle clocks.
REQ-026 IDLECLK SHALL issue cmd_len pulses with tms=0 and tdi=0.
REQ-027 For a TAP reset command, cmd_len SHALL be ignored.
REQ-028 DONE SHALL pulse rsp_valid for exactly 1 cycle, then return to IDLE.
REQ-029 For scan and idle commands with cmd_len=0 or cmd_len>64, the block SHALL issue no tck pulses and SHALL assert rsp_valid and rsp_err 2 cycles after acceptance, with rsp_data=0.
REQ-030 rsp_err SHALL be 0 for all other commands.
REQ-031 rsp_data and rsp_err SHALL hold their values until the next completion.
REQ-032 cmd_valid asserted while cmd_ready=0 SHALL be ignored; no command is queued.
REQ-033 Pulse and bit counters SHALL be 7 bits wide and SHALL NOT wrap within a command.

Reset
REQ-034 While nreset=0 the block SHALL drive tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0 and rsp_data=0.
REQ-035 After nreset deasserts, the block SHALL run the RESET sequence autonomously without asserting rsp_valid, then set cmd_ready=1.
REQ-036 nreset asserted mid-command SHALL abort the command in the next cycle with no rsp_valid; the post-reset TAP reset sequence (REQ-035) SHALL resynchronise the TAP.

Verification
REQ-037 Post-reset with CLK_DIV=2: tms SHALL be 1,1,1,1,1,0 across 6 pulses; cmd_ready SHALL rise after 24 clk cycles of tck activity.
REQ-038 With raifes_dtm attached, IR scan op=01, len=5, data=0x01, then DR scan op=00, len=32, data=0 -> IR rsp_data=0x01; DR rsp_data=0x10001001.
REQ-039 IR scan data=0x10, then DR scan len=32 -> rsp_data=0x00002071 (DTM register capture).
REQ-040 IR=0x11, DR scan len=41 with data {addr 0x10, wdata 0x1, op 2} -> dmi_en/dmi_wen pulse with dmi_addr=0x10 and dmi_wdata=1; a following idle-clocks command len=10 -> exactly 10 pulses with tms=0.
REQ-041 cmd_len=0 and cmd_len=65 -> no tck activity; rsp_valid and rsp_err pulse 2 cycles after acceptance.
REQ-042 nreset pulled low during SHIFT bit 20 of a 41-bit scan -> outputs go to reset values the next cycle, no rsp_valid, then the full RESET sequence is issued.
